// File: rtl/acslip_sample_corrector.sv
// acslip_sample_corrector
// Consumer end of the ACSLIP slip measurement. Compares the slip count against the
// corrections already applied and repeats or deletes single samples of a 16 kHz stream
// so that it tracks the I2S consumer.
// Optional statistics counters are enabled with macro ACSLIP_CORR_STATS_EN.
module acslip_sample_corrector #(
  parameter int ACSLIP_REG_WIDTH = 32,
  parameter int DATA_WIDTH       = 16,
  parameter int SLIP_THRESH      = 2
) (
  input  logic                        wbs_clk_i,
  input  logic                        acslip_rst,
  input  logic [ACSLIP_REG_WIDTH-1:0] acslip_cnt_i,
  input  logic                        corr_en_i,
  input  logic [DATA_WIDTH-1:0]       in_data_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic [DATA_WIDTH-1:0]       out_data_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        insert_pulse_o,
  output logic                        drop_pulse_o,
`ifdef ACSLIP_CORR_STATS_EN
  output logic [15:0]                 ins_cnt_o,
  output logic [15:0]                 drop_cnt_o,
`endif
  output logic [ACSLIP_REG_WIDTH-1:0] corr_cnt_o
);

  localparam int W = ACSLIP_REG_WIDTH;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic signed [W-1:0] THRESH_POS = W'(SLIP_THRESH);
  localparam logic signed [W-1:0] THRESH_NEG = -THRESH_POS;

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  ins_pend_q, ins_pend_d;
  logic                  ins_pulse_q, ins_pulse_d;
  logic                  drop_pulse_q, drop_pulse_d;
  logic [W-1:0]          corr_cnt_q, corr_cnt_d;

  logic signed [W-1:0]   err;
  logic                  hs_in, hs_out;

  // Next-state logic: one correction decision per accepted sample.
  always_comb begin
    // Modular difference read as signed, so a wrapping slip counter is harmless.
    err          = $signed(acslip_cnt_i - corr_cnt_q);
    hs_in        = in_valid_i & in_ready_q;
    hs_out       = out_valid_q & out_ready_i;
    state_d      = state_q;
    data_d       = data_q;
    ins_pend_d   = ins_pend_q;
    corr_cnt_d   = corr_cnt_q;
    ins_pulse_d  = 1'b0;
    drop_pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs_in) begin
          if (corr_en_i && (err <= THRESH_NEG)) begin
            // I2S is behind: swallow this sample, it never reaches the output.
            drop_pulse_d = 1'b1;
            corr_cnt_d   = corr_cnt_q - 1'b1;
          end else begin
            data_d     = in_data_i;
            state_d    = ST_HOLD;
            // corr_en_i only matters here; a later deassert cannot cancel the insert.
            ins_pend_d = corr_en_i && (err >= THRESH_POS);
          end
        end
      end
      default: begin
        if (hs_out) begin
          if (ins_pend_q) begin
            // I2S is ahead: present the same sample once more.
            ins_pend_d  = 1'b0;
            ins_pulse_d = 1'b1;
            corr_cnt_d  = corr_cnt_q + 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
    // Handshake outputs are registered decodes of the next state.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_HOLD);
  end

  // Main state registers.
  always_ff @(posedge wbs_clk_i or posedge acslip_rst) begin
    if (acslip_rst) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      ins_pend_q   <= 1'b0;
      ins_pulse_q  <= 1'b0;
      drop_pulse_q <= 1'b0;
      corr_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      ins_pend_q   <= ins_pend_d;
      ins_pulse_q  <= ins_pulse_d;
      drop_pulse_q <= drop_pulse_d;
      corr_cnt_q   <= corr_cnt_d;
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = out_valid_q;
  assign out_data_o     = data_q;
  assign insert_pulse_o = ins_pulse_q;
  assign drop_pulse_o   = drop_pulse_q;
  assign corr_cnt_o     = corr_cnt_q;

`ifdef ACSLIP_CORR_STATS_EN
  logic [15:0] ins_cnt_q, ins_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating event counters driven by the registered pulses.
  always_comb begin
    ins_cnt_d  = ins_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (ins_pulse_q && (ins_cnt_q != 16'hFFFF))
      ins_cnt_d = ins_cnt_q + 16'd1;
    if (drop_pulse_q && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge wbs_clk_i or posedge acslip_rst) begin
    if (acslip_rst) begin
      ins_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      ins_cnt_q  <= ins_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ins_cnt_o  = ins_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_acslip_sample_corrector.sv
// Directed bench for acslip_sample_corrector: pass-through, insert, drop, backpressure,
// counter wrap, signed extreme and reset while holding a sample.
module tb_acslip_sample_corrector;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] acslip_cnt;
  logic        corr_en;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        ins_p, drop_p;
  logic [31:0] corr_cnt;

  int checks   = 0;
  int failures = 0;

  logic [15:0] got[$];
  int ins_seen  = 0;
  int drop_seen = 0;
  int b, ib, db;

  always #5 clk = ~clk;

  acslip_sample_corrector dut (
    .wbs_clk_i      (clk),
    .acslip_rst     (rst),
    .acslip_cnt_i   (acslip_cnt),
    .corr_en_i      (corr_en),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .out_data_o     (out_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .insert_pulse_o (ins_p),
    .drop_pulse_o   (drop_p),
    .corr_cnt_o     (corr_cnt)
  );

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back(out_data);
    if (ins_p)  ins_seen++;
    if (drop_p) drop_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int idx, input logic [15:0] e);
    logic [15:0] v;
    v = (idx < got.size()) ? got[idx] : 16'hxxxx;
    chk(tag, {16'h0, v}, {16'h0, e});
  endtask

  task automatic send(input logic [15:0] d);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=in_ready_low expected=handshake data=%0h", d);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic mark();
    b  = got.size();
    ib = ins_seen;
    db = drop_seen;
  endtask

  initial begin
    rst = 1'b1; acslip_cnt = '0; corr_en = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    #2;
    do_reset();
    // Reset state
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_out_data", {16'h0, out_data}, 32'h0);
    chk("rst_corr_cnt", corr_cnt, 32'h0);
    chk("rst_pulses", {30'h0, ins_p, drop_p}, 32'h0);
    @(posedge clk); #2;
    chk("rst_in_ready_rise", {31'h0, in_ready}, 32'h1);

    // T1 pass-through
    corr_en = 1'b0; acslip_cnt = 32'd100; mark();
    for (int i = 1; i <= 8; i++) send(16'(i));
    settle();
    chk("t1_count", got.size() - b, 8);
    for (int i = 1; i <= 8; i++) chk_out("t1_data", b + i - 1, 16'(i));
    chk("t1_ins", ins_seen - ib, 0);
    chk("t1_drop", drop_seen - db, 0);
    chk("t1_corr", corr_cnt, 32'h0);

    // T2 insert: err=2 at first sample, err=1 at second
    corr_en = 1'b1; acslip_cnt = 32'd2; mark();
    send(16'hA5A5);
    send(16'h1234);
    settle();
    chk("t2_count", got.size() - b, 3);
    chk_out("t2_d0", b, 16'hA5A5);
    chk_out("t2_d1", b + 1, 16'hA5A5);
    chk_out("t2_d2", b + 2, 16'h1234);
    chk("t2_ins", ins_seen - ib, 1);
    chk("t2_drop", drop_seen - db, 0);
    chk("t2_corr", corr_cnt, 32'h1);

    // T3 drop: fresh counter, err=-2 drops, then err=-1 passes
    do_reset();
    corr_en = 1'b1; acslip_cnt = 32'hFFFF_FFFE; mark();
    send(16'h0011);
    send(16'h0022);
    settle();
    chk("t3_count", got.size() - b, 1);
    chk_out("t3_d0", b, 16'h0022);
    chk("t3_drop", drop_seen - db, 1);
    chk("t3_ins", ins_seen - ib, 0);
    chk("t3_corr", corr_cnt, 32'hFFFF_FFFF);

    // T4 backpressure with insert pending: err = 1 - (-1) = 2
    acslip_cnt = 32'd1; out_ready = 1'b0; mark();
    send(16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_valid", {31'h0, out_valid}, 32'h1);
      chk("t4_data", {16'h0, out_data}, 32'h0000_BEEF);
      chk("t4_no_ins", ins_seen - ib, 0);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    settle();
    chk("t4_count", got.size() - b, 2);
    chk_out("t4_d0", b, 16'hBEEF);
    chk_out("t4_d1", b + 1, 16'hBEEF);
    chk("t4_ins", ins_seen - ib, 1);
    chk("t4_corr", corr_cnt, 32'h0);

    // T5 wrap: corr_cnt=-1, slip steps across zero
    do_reset();
    corr_en = 1'b1; acslip_cnt = 32'hFFFF_FFFE; mark();
    send(16'h0033);
    settle();
    chk("t5_corr_m1", corr_cnt, 32'hFFFF_FFFF);
    acslip_cnt = 32'h0000_0000;
    send(16'h0044);
    settle();
    chk("t5_err1_noins", ins_seen - ib, 0);
    acslip_cnt = 32'h0000_0001;
    send(16'h0055);
    settle();
    chk("t5_count", got.size() - b, 3);
    chk_out("t5_d0", b, 16'h0044);
    chk_out("t5_d1", b + 1, 16'h0055);
    chk_out("t5_d2", b + 2, 16'h0055);
    chk("t5_ins", ins_seen - ib, 1);
    chk("t5_drop", drop_seen - db, 1);
    chk("t5_corr", corr_cnt, 32'h0);
    // Most-negative error must read as negative, not a huge positive value
    acslip_cnt = 32'h8000_0000; mark();
    send(16'h0066);
    settle();
    chk("t5_neg_count", got.size() - b, 0);
    chk("t5_neg_drop", drop_seen - db, 1);
    chk("t5_neg_corr", corr_cnt, 32'hFFFF_FFFF);

    // T6 reset while holding with insert pending
    do_reset();
    corr_en = 1'b1; acslip_cnt = 32'd2; out_ready = 1'b0;
    send(16'h0077);
    chk("t6_hold_valid", {31'h0, out_valid}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("t6_rst_corr", corr_cnt, 32'h0);
    chk("t6_rst_pulses", {30'h0, ins_p, drop_p}, 32'h0);
    chk("t6_rst_data", {16'h0, out_data}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    acslip_cnt = 32'd0; out_ready = 1'b1; mark();
    send(16'h0088);
    settle();
    chk("t6_count", got.size() - b, 1);
    chk_out("t6_d0", b, 16'h0088);
    chk("t6_ins", ins_seen - ib, 0);
    chk("t6_drop", drop_seen - db, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
